vram_fill_engine: RTL and testbench

- Write-side initiator for the 960x540 2bpp memory-mapped VGA frame buffer. Drives the buffer's word write port: xaddr/yaddr/data/wen.
- Fills a CPU-programmed rectangle of 32-bit VRAM words (16 pixels each) with a fixed word, one word per clock. Rows are 60 words of 64-word stride; there are 540 lines.
- Optionally waits for the start of vertical blanking before writing, to avoid tearing. Sits on the OTTER MMIO bus between the CPU and the VGA driver.

---
 rtl/vram_fill_engine.sv | 196 +++++++++++++++++++
 tb/tb_vram_fill_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_engine.sv
// vram_fill_engine
// Rectangle fill initiator for the 960x540 2bpp VGA frame buffer word port.
// Writes one 32-bit word per clock over a latched, clamped rectangle in
// row-major order, optionally deferring the first write until a fresh
// vertical-blanking rising edge so the fill does not tear on screen.
module vram_fill_engine #(
    parameter int COLS = 60,
    parameter int ROWS = 540,
    parameter int XW   = 6,
    parameter int YW   = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          vsync_en,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [31:0]   fill_data,
    input  logic          vblank,
    output logic [XW-1:0] xaddr,
    output logic [YW-1:0] yaddr,
    output logic [31:0]   data,
    output logic          wen,
    output logic          busy,
    output logic          done
);

    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VB = 2'd1,
        S_FILL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Latched arguments and scan position
    logic [XW-1:0] x0_reg, x1_reg, x_reg;
    logic [YW-1:0] y1_reg, y_reg;
    logic [31:0]   fill_reg;

    // vblank synchroniser and edge detector
    logic vb_meta_reg, vb_sync_reg, vb_prev_reg;
    logic vb_rise;

    // Registered output images
    logic [XW-1:0] xaddr_reg, xaddr_next;
    logic [YW-1:0] yaddr_reg, yaddr_next;
    logic [31:0]   data_reg, data_next;
    logic          wen_reg, wen_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic [XW-1:0] x1_clamped;
    logic [YW-1:0] y1_clamped;
    logic          rect_empty;
    logic          start_accept;
    logic          last_word;

    assign x1_clamped   = (x1 > X_MAX) ? X_MAX : x1;
    assign y1_clamped   = (y1 > Y_MAX) ? Y_MAX : y1;
    assign rect_empty   = (x0 > x1_clamped) || (y0 > y1_clamped);
    assign start_accept = (state_reg == S_IDLE) && start && !abort;
    assign last_word    = (x_reg == x1_reg) && (y_reg == y1_reg);
    assign vb_rise      = vb_sync_reg & ~vb_prev_reg;

    // Bring vblank into the clk domain and keep one cycle of history for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vb_meta_reg <= 1'b0;
            vb_sync_reg <= 1'b0;
            vb_prev_reg <= 1'b0;
        end else begin
            vb_meta_reg <= vblank;
            vb_sync_reg <= vb_meta_reg;
            vb_prev_reg <= vb_sync_reg;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort from any active state returns straight to IDLE
    always_comb begin
        state_next = state_reg;
        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_accept) begin
                        if (rect_empty) begin
                            state_next = S_DONE;
                        end else if (vsync_en) begin
                            state_next = S_WAIT_VB;
                        end else begin
                            state_next = S_FILL;
                        end
                    end
                end
                S_WAIT_VB: begin
                    if (vb_rise) begin
                        state_next = S_FILL;
                    end
                end
                S_FILL: begin
                    if (last_word) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Argument latch on accepted start, then row-major advance of the scan position while filling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0_reg   <= '0;
            x1_reg   <= '0;
            y1_reg   <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            fill_reg <= '0;
        end else if (start_accept) begin
            x0_reg   <= x0;
            x1_reg   <= x1_clamped;
            y1_reg   <= y1_clamped;
            x_reg    <= x0;
            y_reg    <= y0;
            fill_reg <= fill_data;
        end else if ((state_reg == S_FILL) && !abort && !last_word) begin
            if (x_reg == x1_reg) begin
                x_reg <= x0_reg;
                y_reg <= y_reg + YW'(1);
            end else begin
                x_reg <= x_reg + XW'(1);
            end
        end
    end

    // Output logic: present the current scan position one cycle later; hold address/data when idle
    always_comb begin
        wen_next   = (state_reg == S_FILL) && !abort;
        xaddr_next = wen_next ? x_reg    : xaddr_reg;
        yaddr_next = wen_next ? y_reg    : yaddr_reg;
        data_next  = wen_next ? fill_reg : data_reg;
        done_next  = (state_reg == S_DONE) && !abort;
        // busy covers waiting, filling and the final write cycle itself
        busy_next  = (state_next == S_WAIT_VB) || (state_next == S_FILL) || wen_next;
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xaddr_reg <= '0;
            yaddr_reg <= '0;
            data_reg  <= '0;
            wen_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            xaddr_reg <= xaddr_next;
            yaddr_reg <= yaddr_next;
            data_reg  <= data_next;
            wen_reg   <= wen_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign xaddr = xaddr_reg;
    assign yaddr = yaddr_reg;
    assign data  = data_reg;
    assign wen   = wen_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Testbench for vram_fill_engine: table vectors and random rectangles checked
// against a list-of-writes reference model, plus hand-written sequences for
// vblank sync, abort/restart, IDLE start+abort, and asynchronous reset.
module tb_vram_fill_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        vsync_en;
    logic [5:0]  x0, x1;
    logic [9:0]  y0, y1;
    logic [31:0] fill_data;
    logic        vblank;
    logic [5:0]  xaddr;
    logic [9:0]  yaddr;
    logic [31:0] data;
    logic        wen;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0] x;
        logic [9:0] y;
    } write_t;

    typedef struct {
        logic [5:0]  x0, x1;
        logic [9:0]  y0, y1;
        logic [31:0] d;
        int          exp_w;
        string       name;
    } vec_t;

    write_t exp_q[$];

    vram_fill_engine #(.COLS(60), .ROWS(540), .XW(6), .YW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .vsync_en  (vsync_en),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .fill_data (fill_data),
        .vblank    (vblank),
        .xaddr     (xaddr),
        .yaddr     (yaddr),
        .data      (data),
        .wen       (wen),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference: the ordered list of word coordinates a fill must visit
    function automatic void build_model(input int ax0, input int ax1, input int ay0, input int ay1);
        int cx1, cy1;
        write_t w;
        exp_q.delete();
        cx1 = (ax1 > 59) ? 59 : ax1;
        cy1 = (ay1 > 539) ? 539 : ay1;
        for (int yy = ay0; yy <= cy1; yy++) begin
            for (int xx = ax0; xx <= cx1; xx++) begin
                w.x = 6'(xx);
                w.y = 10'(yy);
                exp_q.push_back(w);
            end
        end
    endfunction

    // One immediate (vsync_en=0) fill, fully checked
    task automatic run_fill(input logic [5:0] ax0, input logic [5:0] ax1,
                            input logic [9:0] ay0, input logic [9:0] ay1,
                            input logic [31:0] ad, input int exp_w_in, input string name);
        int exp_w;
        int nw = 0, first_k = -1, gap_err = 0, seq_err = 0, busy_err = 0;
        int done_k = -1, n_done = 0;
        string det = "";
        build_model(ax0, ax1, ay0, ay1);
        exp_w = (exp_w_in < 0) ? exp_q.size() : exp_w_in;
        @(negedge clk);
        x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; fill_data = ad;
        vsync_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // scramble inputs mid-fill; they must have no effect
        x0 = 6'($urandom); x1 = 6'($urandom); y0 = 10'($urandom); y1 = 10'($urandom);
        fill_data = $urandom;
        for (int k = 0; k < exp_w + 6; k++) begin
            if (k > 0) @(negedge clk);
            if (wen) begin
                if (first_k < 0) first_k = k;
                if (k != 1 + nw) gap_err++;
                if (nw < exp_q.size()) begin
                    if (xaddr != exp_q[nw].x || yaddr != exp_q[nw].y || data != ad) begin
                        if (seq_err == 0)
                            det = $sformatf("write %0d at (%0d,%0d) data %h, want (%0d,%0d) data %h",
                                            nw, xaddr, yaddr, data, exp_q[nw].x, exp_q[nw].y, ad);
                        seq_err++;
                    end
                end else begin
                    seq_err++;
                end
                if (!busy) busy_err++;
                nw++;
            end
            if (done) begin
                if (done_k < 0) done_k = k;
                n_done++;
                if (busy) busy_err++;
            end
        end
        $display("txn %s: rect x %0d..%0d y %0d..%0d writes=%0d first_k=%0d done_k=%0d",
                 name, ax0, ax1, ay0, ay1, nw, first_k, done_k);
        check({name, "_count"}, nw, exp_w);
        check({name, "_model_count"}, nw, exp_q.size());
        if (exp_w > 0) check({name, "_latency"}, first_k, 1);
        check({name, "_gaps"}, gap_err, 0);
        if (seq_err != 0) $display("  detail %s: %s", name, det);
        check({name, "_addr_data"}, seq_err, 0);
        check({name, "_busy"}, busy_err, 0);
        check({name, "_done_cycle"}, done_k, exp_w + 1);
        check({name, "_done_width"}, n_done, 1);
    endtask

    initial begin
        vec_t vecs[6];
        int bad, cnt, found, nw, stray, done_seen, abort_k, aborted;
        logic [5:0]  rx0, rx1;
        logic [9:0]  ry0, ry1;

        vecs[0] = '{x0: 6'd2,  x1: 6'd4,  y0: 10'd10,  y1: 10'd11,  d: 32'hAAAAAAAA, exp_w: 6,     name: "solid"};
        vecs[1] = '{x0: 6'd58, x1: 6'd63, y0: 10'd539, y1: 10'd600, d: 32'h5A5A0F0F, exp_w: 2,     name: "clamp"};
        vecs[2] = '{x0: 6'd5,  x1: 6'd3,  y0: 10'd0,   y1: 10'd0,   d: 32'h11111111, exp_w: 0,     name: "empty_x"};
        vecs[3] = '{x0: 6'd0,  x1: 6'd0,  y0: 10'd5,   y1: 10'd4,   d: 32'h22222222, exp_w: 0,     name: "empty_y"};
        vecs[4] = '{x0: 6'd7,  x1: 6'd7,  y0: 10'd100, y1: 10'd100, d: 32'hDEADBEEF, exp_w: 1,     name: "single"};
        vecs[5] = '{x0: 6'd0,  x1: 6'd59, y0: 10'd0,   y1: 10'd539, d: 32'hFFFF0000, exp_w: 32400, name: "full"};

        reset = 1'b0; start = 1'b0; abort = 1'b0; vsync_en = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; fill_data = '0; vblank = 1'b0;

        // Reset state
        #3;
        check("reset_outputs", {wen, busy, done, xaddr, yaddr, data}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {wen, busy, done}, 0);

        // Table vectors
        for (int i = 0; i < 6; i++)
            run_fill(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].d, vecs[i].exp_w, vecs[i].name);

        // Random rectangles against the model
        for (int i = 0; i < 10; i++) begin
            rx0 = 6'($urandom_range(0, 63));
            rx1 = 6'($urandom_range(0, 63));
            ry0 = 10'($urandom_range(500, 560));
            ry1 = 10'(ry0 + 10'($urandom_range(0, 3)));
            run_fill(rx0, rx1, ry0, ry1, $urandom, -1, $sformatf("rand%0d", i));
        end

        // Vblank sync: vblank already high at start must not trigger
        vblank = 1'b1;
        repeat (5) @(negedge clk);
        x0 = 6'd0; x1 = 6'd1; y0 = 10'd3; y1 = 10'd3; fill_data = 32'hC0FFEE00;
        vsync_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; vsync_en = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (wen || !busy) bad++;
        end
        vblank = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wen || !busy) bad++;
        end
        check("vb_hold", bad, 0);
        vblank = 1'b1;
        cnt = 0; found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(posedge clk);
            cnt++;
            #1;
            if (wen) found = 1;
        end
        $display("txn vblank: first write %0d clocks after rise, addr (%0d,%0d)", cnt, xaddr, yaddr);
        check("vb_latency_ok", (found == 1 && cnt >= 3 && cnt <= 4) ? 1 : 0, 1);
        check("vb_first_addr", {xaddr, yaddr}, {6'd0, 10'd3});
        @(negedge clk);
        @(negedge clk);
        check("vb_second_write", {wen, xaddr, yaddr, data}, {1'b1, 6'd1, 10'd3, 32'hC0FFEE00});
        @(negedge clk);
        check("vb_done", {done, wen, busy}, {1'b1, 1'b0, 1'b0});
        vblank = 1'b0;

        // Abort on the 5th write, with an ignored start during the fill
        @(negedge clk);
        x0 = 6'd0; x1 = 6'd9; y0 = 10'd7; y1 = 10'd7; fill_data = 32'h12345678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 0; stray = 0; done_seen = 0; aborted = 0; abort_k = -10;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            abort = 1'b0; start = 1'b0;
            if (k == abort_k + 1)
                check("abort_stops", {wen, busy}, 0);
            if (wen) begin
                if (xaddr != 6'(nw) || yaddr != 10'd7 || data != 32'h12345678) stray++;
                nw++;
                if (nw == 2) begin
                    start = 1'b1; x0 = 6'd30; x1 = 6'd31; y0 = 10'd0; y1 = 10'd0; fill_data = '0;
                end
                if (nw == 5 && aborted == 0) begin
                    abort = 1'b1; aborted = 1; abort_k = k;
                end
            end
            if (done) done_seen++;
        end
        $display("txn abort: writes=%0d done_pulses=%0d", nw, done_seen);
        check("abort_writes", nw, 5);
        check("abort_no_done", done_seen, 0);
        check("abort_busy_start_ignored", stray, 0);
        run_fill(6'd10, 6'd12, 10'd20, 10'd20, 32'h0BADF00D, 3, "restart");

        // start and abort together in IDLE: nothing starts
        @(negedge clk);
        x0 = 6'd0; x1 = 6'd3; y0 = 10'd0; y1 = 10'd0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (wen || busy || done) bad++;
        end
        $display("txn idle_start_abort: active cycles=%0d", bad);
        check("idle_start_abort", bad, 0);

        // Asynchronous reset mid-fill
        @(negedge clk);
        x0 = 6'd0; x1 = 6'd19; y0 = 10'd1; y1 = 10'd1; fill_data = 32'h77777777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_writing", wen, 1);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_clear", {wen, busy, done, xaddr, yaddr, data}, 0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (wen || busy || done) bad++;
        end
        $display("txn reset_midfill: active cycles after release=%0d", bad);
        check("reset_idle_after", bad, 0);
        run_fill(6'd1, 6'd2, 10'd2, 10'd3, 32'hA5A5A5A5, 4, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
